// File: rtl/csr_dec_hls_deadlock_reporter.sv
// csr_dec_hls_deadlock_reporter: qualifies persistent monitor blocking and reports it once over valid/ready.
module csr_dec_hls_deadlock_reporter #(
   parameter int NUM_MON   = 4,
   parameter int THRESHOLD = 1024,
   parameter int CNT_W     = 16,
   parameter int EVT_W     = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_MON-1:0] block_in,
   input  logic               clear,
   output logic               report_valid,
   input  logic               report_ready,
   output logic [NUM_MON-1:0] report_mask,
   output logic [CNT_W-1:0]   report_cycles,
   output logic               deadlock_flag,
   output logic [EVT_W-1:0]   event_count,
   output logic               busy
);
   if (THRESHOLD < 1 || longint'(THRESHOLD) >= (longint'(1) << CNT_W)) begin : g_bad_threshold
      $error("THRESHOLD must lie in 1..2^CNT_W-1");
   end
   typedef enum logic [1:0] {IDLE, WATCH, REPORT, LATCHED} state_t;
   localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESHOLD);
   localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESHOLD - 1);
   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [NUM_MON-1:0] mask;
   logic               any_blk;
   assign any_blk = |block_in;
   assign busy    = state != IDLE;
   // cnt and mask are zero whenever IDLE, so IDLE and WATCH share one window update
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         mask          <= '0;
         report_valid  <= 1'b0;
         report_mask   <= '0;
         report_cycles <= '0;
         deadlock_flag <= 1'b0;
         event_count   <= '0;
      end else if (clear) begin
         state         <= IDLE;
         cnt           <= '0;
         mask          <= '0;
         report_valid  <= 1'b0;
         deadlock_flag <= 1'b0;
      end else begin
         case (state)
            IDLE, WATCH: begin
               if (!any_blk) begin
                  state <= IDLE;
                  cnt   <= '0;
                  mask  <= '0;
               end else begin
                  cnt  <= cnt + CNT_W'(1);
                  mask <= mask | block_in;
                  if (cnt == THR_M1) begin
                     state         <= REPORT;
                     report_valid  <= 1'b1;
                     report_mask   <= mask | block_in;
                     report_cycles <= THR;
                  end else begin
                     state <= WATCH;
                  end
               end
            end
            REPORT: begin
               if (report_valid && report_ready) begin
                  state         <= LATCHED;
                  report_valid  <= 1'b0;
                  deadlock_flag <= 1'b1;
                  if (event_count != '1) event_count <= event_count + EVT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/csr_dec_hls_deadlock_reporter.md
Name: csr_dec_hls_deadlock_reporter

Overview:
- Consumer end of the HLS deadlock monitors' `block` outputs.
- Qualifies a block indication that persists for THRESHOLD consecutive cycles.
- On qualification, snapshots which monitors were blocking and delivers one report over a valid/ready channel to the CSR/debug aggregator.
- Holds a sticky deadlock flag until software clears it.

Parameters:
- NUM_MON, 4, number of monitor `block` inputs.
- THRESHOLD, 1024, consecutive blocked cycles required to qualify; legal range 1..2^CNT_W-1.
- CNT_W, 16, width of the persistence counter and of the reported cycle count.
- EVT_W, 8, width of the saturating event counter.

Ports:
- clock  input  1  Clock; all logic on the rising edge.
- reset  input  1  Synchronous, active-high reset.
- block_in  input  NUM_MON  One bit per monitor `block` output; level-sensitive.
- clear  input  1  Single-cycle pulse from CSR; aborts or clears a report.
- report_valid  output  1  Report available.
- report_ready  input  1  Aggregator accepts the report.
- report_mask  output  NUM_MON  OR of block_in over the qualifying window.
- report_cycles  output  CNT_W  Persistence count at qualification; always equals THRESHOLD.
- deadlock_flag  output  1  Sticky; set on report handshake.
- event_count  output  EVT_W  Count of accepted reports; saturates at all-ones.
- busy  output  1  High when state is not IDLE.

Behaviour:
- Reset: state=IDLE; cnt=0, mask=0; report_valid=0, report_mask=0, report_cycles=0, deadlock_flag=0, event_count=0, busy=0.
- Define any_blk = |block_in, sampled at each rising edge.
- States: IDLE, WATCH, REPORT, LATCHED.
- clear takes priority over every transition below, in every state:
  - next state IDLE; cnt=0, mask=0; report_valid=0; deadlock_flag=0.
  - event_count unchanged.
  - block_in in the clear cycle is ignored.
- IDLE:
  - any_blk=0: stay.
  - any_blk=1 and THRESHOLD=1: go to REPORT; mask=block_in; cnt=1.
  - any_blk=1 otherwise: go to WATCH; cnt=1; mask=block_in.
- WATCH:
  - any_blk=0: go to IDLE; cnt=0, mask=0. A single idle cycle breaks the window.
  - any_blk=1 and cnt==THRESHOLD-1: go to REPORT; cnt=THRESHOLD; mask|=block_in.
  - any_blk=1 otherwise: cnt+=1; mask|=block_in.
  - The set of blocking bits may change within the window, provided some bit is high every cycle.
- Report timing:
  - report_valid rises on the edge that samples the THRESHOLD-th consecutive any_blk=1 cycle.
  - It is visible in the following cycle (latency THRESHOLD cycles from first sample).
- REPORT:
  - report_valid=1; report_mask=mask; report_cycles=cnt.
  - All three are stable until the handshake.
  - block_in is ignored; deassertion of block does not withdraw the report.
  - report_valid&report_ready: go to LATCHED; deadlock_flag<=1; event_count+=1, saturating at 2^EVT_W-1; report_valid<=0 on the same edge.
  - A handshake in the first valid cycle is legal (ready may be held high).
- LATCHED:
  - deadlock_flag=1; report_valid=0; block_in ignored.
  - Stays until clear; no re-report without clear.
- busy = (state != IDLE); combinational decode of the state register.
- Counter width: cnt never exceeds THRESHOLD, so no wrap. THRESHOLD >= 2^CNT_W is illegal; flag it as an elaboration-time error.
- No combinational path from report_ready to report_valid or to the data outputs.

Test Plan:
Bench uses NUM_MON=4, THRESHOLD=8, CNT_W=16, EVT_W=2.
- Qualification:
  - Stimulus: block_in=4'b0001 for 8 cycles, report_ready=1.
  - Response: report_valid high for exactly 1 cycle, the cycle after the 8th sample; report_mask=0001, report_cycles=8; next cycle deadlock_flag=1, event_count=1.
- Broken window:
  - Stimulus: block_in=0010 for 7 cycles, 0000 for 1 cycle, 0010 for 7 cycles.
  - Response: report_valid never asserts; busy drops for 1 cycle after the gap.
- Rotating blockers:
  - Stimulus: block_in=0001,0010,0100,1000,0001,0010,0100,1000.
  - Response: report with mask=1111, cycles=8.
- Backpressure:
  - Stimulus: qualify with report_ready=0 for 5 cycles while block_in drops to 0, then ready=1.
  - Response: valid held 6 cycles with mask/cycles stable; handshake on the 6th cycle; deadlock_flag=1.
- Clear:
  - Stimulus: pulse clear in REPORT; separately in WATCH at cnt=5; separately in LATCHED.
  - Response: each returns to IDLE next cycle with valid=0 and flag=0; event_count unchanged by the REPORT abort.
  - Then re-qualify 4 times: event_count saturates at 3.
- Reset mid-operation:
  - Stimulus: assert reset in WATCH at cnt=6 and again in REPORT.
  - Response: all outputs return to reset values next cycle; 8 further blocked cycles are required to report.
